uart_tx_wr_arb: RTL and testbench
=================================

UART_TX_WR_ARB -- requirements
Module: uart_tx_wr_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, which is the requester word width (a multiple of 8).
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, which is the UART TX FIFO write data width.
REQ-003 SHALL use one clock and a synchronous, active-high reset: i_uart_tx_wr_arb_clk  in  1  clock; i_uart_tx_wr_arb_rst  in  1  synchronous active-high reset.
REQ-004 SHALL have i_uart_tx_wr_arb_valid  in  2  per-requester request, held until done.
REQ-005 SHALL have i_uart_tx_wr_arb_data0 and i_uart_tx_wr_arb_data1  in  DATA_WIDTH  requester words, byte 0 = bits [7:0].
REQ-006 SHALL have i_uart_tx_wr_arb_size0 and i_uart_tx_wr_arb_size1  in  2  byte count: 00=1, 01=2, 10=4, 11=4.
REQ-007 SHALL have o_uart_tx_wr_arb_done  out  2  one-cycle completion pulse per requester.
REQ-008 SHALL have o_uart_tx_wr_arb_err  out  2  timeout abort flag, valid with done.
REQ-009 SHALL have o_uart_tx_wr_arb_busy  out  1  high in any state other than IDLE.
REQ-010 SHALL have i_uart_tx_wr_arb_fifo_full  in  1  the registered TX FIFO full flag.
REQ-011 SHALL have o_uart_tx_wr_arb_fifo_winc  out  1  FIFO write increment.
REQ-012 SHALL have o_uart_tx_wr_arb_fifo_wdata  out  BYTE_WIDTH  FIFO write byte.

Function
REQ-013 SHALL implement the FSM states IDLE, WRITE, GAP and DONE, with next state registered.
REQ-014 In IDLE, with any valid high, SHALL grant one requester, latch its data word and byte count, and move to WRITE on the next cycle.
REQ-015 SHALL arbitrate round-robin: when both requesters are valid, the grant goes to the requester not granted last; a single valid requester always wins.
REQ-016 WRITE SHALL drive winc = !fifo_full combinationally and wdata = the lowest unsent byte; while full, it holds WRITE with winc=0 and wdata stable.
REQ-017 On a WRITE cycle with winc=1, SHALL shift out the byte, decrement the remaining count, and go to GAP if bytes remain, otherwise DONE.
REQ-018 GAP SHALL last exactly one cycle with winc=0, so the registered full flag reflects the last write, then return to WRITE.
REQ-019 DONE SHALL pulse done[grant] for one cycle, record last_grant=grant, and return to IDLE; a request still valid in that IDLE cycle is re-accepted (the requester must drop valid after done).
REQ-020 SHALL emit bytes little-endian: data[7:0] first, then [15:8], and so on.
REQ-021 Latency: with full low, an N-byte request accepted in IDLE at cycle 0 writes at cycles 1, 3, ..., 2N-1 and pulses done at cycle 2N.
REQ-022 SHALL ignore valid deassertion or data/size changes after the grant; the latched transaction completes.
REQ-023 SHALL ignore valid in any state other than IDLE.
REQ-024 SHALL never assert winc while fifo_full=1.
REQ-025 SHALL set busy = (state != IDLE).

Reset
REQ-026 Reset SHALL force state=IDLE, last_grant=1 (requester 0 wins the first tie), byte count=0, and shift register=0.
REQ-027 Reset SHALL force winc=0, wdata=0, done=00, err=00 and busy=0 from the first cycle after reset is sampled.
REQ-028 Reset mid-transaction SHALL abort without a done pulse; bytes already written remain in the FIFO.

Configuration
REQ-029 With macro UART_TX_WR_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL count consecutive WRITE cycles with full=1 and clear on any write or on entering WRITE.
REQ-030 With UART_TX_WR_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES=65535 SHALL move to DONE, pulse done[grant] and err[grant] together, and discard the unsent bytes.
REQ-031 Without UART_TX_WR_ARB_TIMEOUT_EN, SHALL wait indefinitely on full, tie err to 0, and synthesize no counter.

Structure
REQ-032 Shared package uart_tx_wr_arb_pkg SHALL hold the FSM state encoding (IDLE=2'b00, WRITE=2'b01, GAP=2'b10, DONE=2'b11), the size encodings, the size-to-byte-count mapping, and TIMEOUT_CYCLES.
REQ-033 SHALL place the round-robin grant logic and the last_grant register in one sub-module, uart_tx_wr_rr_arb (inputs valid[1:0] and an advance strobe; output grant).

Verification
REQ-034 Reset, then valid=01, data0=0x0000_0041, size0=00, full=0 -> winc at cycle 1 with wdata=0x41, done=01 at cycle 2, err=00.
REQ-035 valid=10, data1=0xDDCC_BBAA, size1=10 -> wdata 0xAA, 0xBB, 0xCC, 0xDD at cycles 1, 3, 5, 7; done=10 at cycle 8.
REQ-036 Both valid continuously, size=00, requester drops valid the cycle after its done -> grants alternate 0, 1, 0, 1; first grant to requester 0 after reset.
REQ-037 4-byte request with full=1 from cycle 2 to cycle 9 -> winc=0 in cycles 2-9, wdata holds 0xBB, second byte written at cycle 10, no byte lost or duplicated.
REQ-038 Reset asserted during GAP of a 4-byte transfer -> next cycle IDLE, busy=0, no done pulse, and a new request is accepted normally.
REQ-039 With UART_TX_WR_ARB_TIMEOUT_EN defined and full held high for 65535 WRITE cycles -> done and err pulse together for the granted requester; without the macro -> no done pulse and err stays 0.

Source files
------------

// File: rtl/uart_tx_wr_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_wr_arb_pkg
// Shared definitions for the two-requester UART TX FIFO write arbiter:
//   - FSM state encoding (IDLE/WRITE/GAP/DONE)
//   - requester size encodings and the size-to-byte-count mapping
//   - TIMEOUT_CYCLES, used only when UART_TX_WR_ARB_TIMEOUT_EN is defined
// -----------------------------------------------------------------------------
package uart_tx_wr_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b01;
    localparam logic [1:0] ST_GAP   = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [1:0] SIZE_1B     = 2'b00;
    localparam logic [1:0] SIZE_2B     = 2'b01;
    localparam logic [1:0] SIZE_4B     = 2'b10;
    localparam logic [1:0] SIZE_4B_ALT = 2'b11;

    // Consecutive stalled WRITE cycles tolerated before a transfer is aborted.
    localparam int unsigned TIMEOUT_CYCLES = 65535;

    // Number of bytes to send for a requester size code.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_1B: n = 3'd1;
            SIZE_2B: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_tx_wr_rr_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_wr_rr_arb
// Two-way round-robin grant with its last_grant history register.
// Ports:
//   i_rr_clk      clock
//   i_rr_rst      synchronous active-high reset (last_grant -> 1, so
//                 requester 0 wins the first tie)
//   i_rr_valid    per-requester request
//   i_rr_advance  strobe: the current grant has been taken, remember it
//   o_rr_grant    index of the requester that wins this cycle
// -----------------------------------------------------------------------------
module uart_tx_wr_rr_arb (
    input  logic       i_rr_clk,
    input  logic       i_rr_rst,
    input  logic [1:0] i_rr_valid,
    input  logic       i_rr_advance,
    output logic       o_rr_grant
);

    logic last_grant_q;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        if (i_rr_valid == 2'b11) begin
            o_rr_grant = ~last_grant_q;
        end else begin
            o_rr_grant = i_rr_valid[1];
        end
    end

    always_ff @(posedge i_rr_clk) begin
        if (i_rr_rst) begin
            last_grant_q <= 1'b1;
        end else if (i_rr_advance) begin
            last_grant_q <= o_rr_grant;
        end
    end

endmodule

// File: rtl/uart_tx_wr_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_wr_arb
// Arbitrates two requesters onto a byte-wide UART TX FIFO write port. A granted
// word of 1, 2 or 4 bytes is written little-endian, one byte every other cycle
// (WRITE then GAP) so the registered FIFO full flag always reflects the
// previous write before the next one is attempted.
//
// Handshake: a requester raises valid[i] with data/size stable and holds it
// until it sees a one-cycle done[i]; data, size and valid are only sampled in
// the IDLE cycle in which the grant is taken. A requester that keeps valid
// high through the IDLE cycle after done is accepted again.
//
// Ports:
//   i_uart_tx_wr_arb_clk / _rst     clock, synchronous active-high reset
//   i_uart_tx_wr_arb_valid[1:0]     per-requester request
//   i_uart_tx_wr_arb_data0/1        requester words, byte 0 = bits [7:0]
//   i_uart_tx_wr_arb_size0/1        00=1 byte, 01=2 bytes, 1x=4 bytes
//   o_uart_tx_wr_arb_done[1:0]      completion pulse for the granted requester
//   o_uart_tx_wr_arb_err[1:0]       timeout abort flag, qualified by done
//   o_uart_tx_wr_arb_busy           state != IDLE
//   i_uart_tx_wr_arb_fifo_full      registered TX FIFO full flag
//   o_uart_tx_wr_arb_fifo_winc      FIFO write strobe
//   o_uart_tx_wr_arb_fifo_wdata     FIFO write byte
//   o_uart_tx_wr_arb_state          FSM state, for debug/checkers
//
// Build option: define UART_TX_WR_ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES consecutive stalled WRITE cycles (done+err). Without it the
// arbiter waits on full indefinitely and err is tied low.
// -----------------------------------------------------------------------------
module uart_tx_wr_arb
    import uart_tx_wr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  i_uart_tx_wr_arb_clk,
    input  logic                  i_uart_tx_wr_arb_rst,
    input  logic [1:0]            i_uart_tx_wr_arb_valid,
    input  logic [DATA_WIDTH-1:0] i_uart_tx_wr_arb_data0,
    input  logic [DATA_WIDTH-1:0] i_uart_tx_wr_arb_data1,
    input  logic [1:0]            i_uart_tx_wr_arb_size0,
    input  logic [1:0]            i_uart_tx_wr_arb_size1,
    output logic [1:0]            o_uart_tx_wr_arb_done,
    output logic [1:0]            o_uart_tx_wr_arb_err,
    output logic                  o_uart_tx_wr_arb_busy,
    input  logic                  i_uart_tx_wr_arb_fifo_full,
    output logic                  o_uart_tx_wr_arb_fifo_winc,
    output logic [BYTE_WIDTH-1:0] o_uart_tx_wr_arb_fifo_wdata,
    output logic [1:0]            o_uart_tx_wr_arb_state
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [2:0]            cnt_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  grant_q;
    logic                  rr_grant;
    logic                  accept;
    logic                  write_fire;
    logic                  to_hit;
    logic [1:0]            grant_onehot;

    assign accept     = (state_q == ST_IDLE) && (|i_uart_tx_wr_arb_valid);
    assign write_fire = (state_q == ST_WRITE) && !i_uart_tx_wr_arb_fifo_full;

    // History is advanced at grant time: last_grant is only consulted in
    // IDLE, so updating it here is indistinguishable from updating in DONE.
    uart_tx_wr_rr_arb u_rr_arb (
        .i_rr_clk     (i_uart_tx_wr_arb_clk),
        .i_rr_rst     (i_uart_tx_wr_arb_rst),
        .i_rr_valid   (i_uart_tx_wr_arb_valid),
        .i_rr_advance (accept),
        .o_rr_grant   (rr_grant)
    );

`ifdef UART_TX_WR_ARB_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        err_q;

    // The final stalled cycle that completes the run triggers the abort.
    assign to_hit = (state_q == ST_WRITE) && i_uart_tx_wr_arb_fifo_full &&
                    (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_uart_tx_wr_arb_clk) begin
        if (i_uart_tx_wr_arb_rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state_d == ST_WRITE) && (state_q != ST_WRITE)) begin
                to_cnt_q <= '0;
            end else if (write_fire) begin
                to_cnt_q <= '0;
            end else if (state_q == ST_WRITE) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (to_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_WRITE;
            ST_WRITE: begin
                if (to_hit) begin
                    state_d = ST_DONE;
                end else if (write_fire) begin
                    state_d = (cnt_q == 3'd1) ? ST_DONE : ST_GAP;
                end
            end
            ST_GAP:   state_d = ST_WRITE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_uart_tx_wr_arb_clk) begin
        if (i_uart_tx_wr_arb_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= rr_grant;
                shreg_q <= rr_grant ? i_uart_tx_wr_arb_data1 : i_uart_tx_wr_arb_data0;
                cnt_q   <= size_to_bytes(rr_grant ? i_uart_tx_wr_arb_size1
                                                  : i_uart_tx_wr_arb_size0);
            end else if (to_hit) begin
                // Abort: unsent bytes are dropped.
                cnt_q   <= '0;
                shreg_q <= '0;
            end else if (write_fire) begin
                shreg_q <= shreg_q >> BYTE_WIDTH;
                cnt_q   <= cnt_q - 3'd1;
            end
        end
    end

    assign grant_onehot = grant_q ? 2'b10 : 2'b01;

    assign o_uart_tx_wr_arb_fifo_winc  = write_fire;
    assign o_uart_tx_wr_arb_fifo_wdata = (state_q == ST_WRITE) ? shreg_q[BYTE_WIDTH-1:0] : '0;
    assign o_uart_tx_wr_arb_done       = (state_q == ST_DONE) ? grant_onehot : 2'b00;
    assign o_uart_tx_wr_arb_busy       = (state_q != ST_IDLE);
    assign o_uart_tx_wr_arb_state      = state_q;

`ifdef UART_TX_WR_ARB_TIMEOUT_EN
    assign o_uart_tx_wr_arb_err = ((state_q == ST_DONE) && err_q) ? grant_onehot : 2'b00;
`else
    assign o_uart_tx_wr_arb_err = 2'b00;
`endif

endmodule

// File: tb/tb_uart_tx_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_wr_arb
// Drives directed and random transactions into uart_tx_wr_arb. For each
// accepted request a reference model (round-robin by rule, byte timing from
// the full-flag schedule) pushes the expected FIFO bytes with their write
// cycles and the expected done/err pulse into queues; a monitor pops them as
// the DUT writes/completes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_wr_arb;
    import uart_tx_wr_arb_pkg::*;

    localparam int DW = 32;
    localparam int BW = 8;
`ifdef UART_TX_WR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    valid = 2'b00;
    logic [DW-1:0] d0 = '0;
    logic [DW-1:0] d1 = '0;
    logic [1:0]    s0 = 2'b00;
    logic [1:0]    s1 = 2'b00;
    logic          full = 1'b0;
    logic [1:0]    done;
    logic [1:0]    err;
    logic          busy;
    logic          winc;
    logic [BW-1:0] wdata;
    logic [1:0]    state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_wr_arb #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW)) dut (
        .i_uart_tx_wr_arb_clk        (clk),
        .i_uart_tx_wr_arb_rst        (rst),
        .i_uart_tx_wr_arb_valid      (valid),
        .i_uart_tx_wr_arb_data0      (d0),
        .i_uart_tx_wr_arb_data1      (d1),
        .i_uart_tx_wr_arb_size0      (s0),
        .i_uart_tx_wr_arb_size1      (s1),
        .o_uart_tx_wr_arb_done       (done),
        .o_uart_tx_wr_arb_err        (err),
        .o_uart_tx_wr_arb_busy       (busy),
        .i_uart_tx_wr_arb_fifo_full  (full),
        .o_uart_tx_wr_arb_fifo_winc  (winc),
        .o_uart_tx_wr_arb_fifo_wdata (wdata),
        .o_uart_tx_wr_arb_state      (state)
    );

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [3:0]    exp_done_q[$];      // {err, done}
    int            exp_done_cyc_q[$];
    bit            full_pat[int];      // full value per absolute cycle
    int            n_checks = 0;
    int            n_fail = 0;
    int            last_grant_m = 1;

    function automatic bit full_at(input int c);
        return full_pat.exists(c) ? full_pat[c] : 1'b0;
    endfunction

    // full for cycle c is applied just after the edge that starts cycle c
    initial forever begin
        @(posedge clk);
        #1;
        full = full_at(cyc);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: bytes little-endian, first write attempt the cycle
    // after acceptance, at least two cycles between writes, stalled while
    // full, optional abort after TIMEOUT_CYCLES consecutive stalls.
    task automatic model_txn(input int c0, input int g, input logic [DW-1:0] data,
                             input logic [1:0] size, output int done_c);
        int n, t, run, k;
        bit aborted;
        logic [1:0] oh;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        t = c0 + 1;
        run = 0;
        k = 0;
        aborted = 1'b0;
        while (k < n && !aborted) begin
            if (full_at(t)) begin
                run++;
                if (TO_EN && run == int'(TIMEOUT_CYCLES)) aborted = 1'b1;
                else t++;
            end else begin
                exp_q.push_back(data[8*k +: 8]);
                exp_cyc_q.push_back(t);
                run = 0;
                k++;
                t += 2;
            end
        end
        oh = (g == 1) ? 2'b10 : 2'b01;
        done_c = aborted ? t + 1 : t - 1;
        exp_done_q.push_back({aborted ? oh : 2'b00, oh});
        exp_done_cyc_q.push_back(done_c);
    endtask

    // ---------------- driver ----------------
    task automatic run_txn(input logic [1:0] v, input logic [DW-1:0] a0, input logic [1:0] z0,
                           input logic [DW-1:0] a1, input logic [1:0] z1,
                           input int st_lo, input int st_hi, input bit rnd_full);
        int g, c0, dc, guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy && guard < 100);
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_wait: busy still 1 after %0d cycles", guard);
        end
        valid = v;
        d0 = a0; s0 = z0;
        d1 = a1; s1 = z1;
        c0 = cyc;
        g = (v == 2'b11) ? 1 - last_grant_m : (v == 2'b10 ? 1 : 0);
        last_grant_m = g;
        if (st_lo >= 0) for (int c = st_lo; c <= st_hi; c++) full_pat[c0 + c] = 1'b1;
        if (rnd_full) for (int c = 1; c <= 60; c++) full_pat[c0 + c] = ($urandom_range(0, 2) == 0);
        model_txn(c0, g, g ? a1 : a0, g ? z1 : z0, dc);
        // After the grant: scramble inputs, maybe withdraw the winner early
        @(posedge clk);
        #1;
        d0 = $urandom; d1 = $urandom;
        s0 = 2'($urandom_range(0, 3)); s1 = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) valid[g] = 1'b0;
        forever begin
            @(negedge clk);
            if (done != 2'b00) break;
            if (cyc > dc + 4) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_wait: no done pulse, expected at cycle %0d", dc);
                break;
            end
        end
        valid[g] = 1'b0;
        full_pat.delete();
    endtask

    // ---------------- monitor ----------------
    bit            prev_hold = 1'b0;
    logic [BW-1:0] prev_wd = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (state == ST_WRITE) chk("winc_vs_full", {63'd0, winc}, {63'd0, !full});
            if (prev_hold && state == ST_WRITE) chk("wdata_hold", {56'd0, wdata}, {56'd0, prev_wd});
            prev_hold = (state == ST_WRITE) && full;
            prev_wd = wdata;
            if (winc) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: wdata 0x%0h, no byte expected", wdata);
                end else begin
                    chk("wdata", {56'd0, wdata}, {56'd0, exp_q.pop_front()});
                    chk("write_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                end
            end
            if (done != 2'b00) begin
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done %b err %b, none expected", done, err);
                end else begin
                    chk("done_err", {60'd0, err, done}, {60'd0, exp_done_q.pop_front()});
                    chk("done_cycle", 64'(cyc), 64'(exp_done_cyc_q.pop_front()));
                end
            end else begin
                chk("err_without_done", {62'd0, err}, 64'd0);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_winc",  {63'd0, winc}, 64'd0);
        chk("rst_wdata", {56'd0, wdata}, 64'd0);
        chk("rst_done",  {62'd0, done}, 64'd0);
        chk("rst_err",   {62'd0, err}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_state", {62'd0, state}, 64'd0);
        rst = 1'b0;
        last_grant_m = 1;

        // single byte from requester 0, then four bytes from requester 1
        run_txn(2'b01, 32'h0000_0041, 2'b00, 32'h0, 2'b00, -1, -1, 1'b0);
        run_txn(2'b10, 32'h1234_5678, 2'b11, 32'hDDCC_BBAA, 2'b10, -1, -1, 1'b0);

        // both requesting: grants alternate
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, $urandom, 2'b00, $urandom, 2'b00, -1, -1, 1'b0);

        // 4-byte transfer with full held over cycles 2..9
        run_txn(2'b01, 32'hDDCC_BBAA, 2'b10, 32'h0, 2'b00, 2, 9, 1'b0);

        // reset during GAP aborts without done
        do @(negedge clk); while (busy);
        valid = 2'b01;
        d0 = 32'h4433_2211;
        s0 = 2'b10;
        c0 = cyc;
        exp_q.push_back(8'h11);
        exp_cyc_q.push_back(c0 + 1);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_gap_state", {62'd0, state}, {62'd0, ST_GAP});
        rst = 1'b1;
        valid = 2'b00;
        @(negedge clk);
        chk("mid_rst_busy",  {63'd0, busy}, 64'd0);
        chk("mid_rst_done",  {62'd0, done}, 64'd0);
        chk("mid_rst_winc",  {63'd0, winc}, 64'd0);
        chk("mid_rst_state", {62'd0, state}, {62'd0, ST_IDLE});
        rst = 1'b0;
        last_grant_m = 1;
        run_txn(2'b11, 32'hCAFE_F00D, 2'b01, 32'h8765_4321, 2'b10, -1, -1, 1'b0);

        // random mix, with random full stalls
        for (int i = 0; i < 24; i++)
            run_txn(2'($urandom_range(1, 3)), $urandom, 2'($urandom_range(0, 3)),
                    $urandom, 2'($urandom_range(0, 3)), -1, -1, ($urandom_range(0, 1) == 1));

        // long stall: aborts with err when the timeout is built in, else waits
        run_txn(2'b10, 32'h0, 2'b00, 32'h5566_7788, 2'b10, 1, 66000, 1'b0);
        run_txn(2'b01, 32'h0000_00E7, 2'b00, 32'h0, 2'b00, -1, -1, 1'b0);

        repeat (5) @(negedge clk);
        chk("bytes_outstanding", 64'(exp_q.size()), 64'd0);
        chk("done_outstanding",  64'(exp_done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
